// File: rtl/spram_bank_ctrl.sv
// spram_bank_ctrl
//   Tiles LANES x BANKS SP256K single-port RAMs into one (16*LANES)-bit wide,
//   (16K*BANKS)-deep memory behind a valid/ready request port. Each bank has
//   its own low-power sequencer (ACTIVE -> STANDBY -> SLEEP -> WAKE -> ACTIVE)
//   that parks idle banks and wakes them transparently on access.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   lp_en        enables automatic low-power sequencing
//   req_*        request port (valid/ready, we, addr, wdata, nibble mask)
//   rsp_valid    one-cycle pulse, read data valid on rsp_rdata
//   rsp_rdata    read data, holds its last value between responses
//   bank_sleep   per-bank SLEEP status

// sp256k_model
//   Behavioural stand-in for one SP256K macro (16K x 16, nibble write enables,
//   registered read data, inert while in standby/sleep/power-off).
// Ports
//   clk, ad, di, maskwe, we, cs, stdby, sleep, pwroff_n, dout
module sp256k_model (
    input  logic        clk,
    input  logic [13:0] ad,
    input  logic [15:0] di,
    input  logic [3:0]  maskwe,
    input  logic        we,
    input  logic        cs,
    input  logic        stdby,
    input  logic        sleep,
    input  logic        pwroff_n,
    output logic [15:0] dout
);
    logic [15:0] mem [16384];
    logic [15:0] dout_q;
    logic [15:0] dout_d;
    logic [15:0] wr_word;
    logic        en;

    assign en = cs && !stdby && !sleep && pwroff_n;

    // Merge masked nibbles into the stored word; read data only updates on a read
    always_comb begin
        wr_word = mem[ad];
        for (int n = 0; n < 4; n++) begin
            if (maskwe[n]) begin
                wr_word[4*n +: 4] = di[4*n +: 4];
            end
        end
        dout_d = (en && !we) ? mem[ad] : dout_q;
    end

    // Array and output register; like the hard macro, neither is reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[ad] <= wr_word;
        end
        dout_q <= dout_d;
    end

    assign dout = dout_q;
endmodule

module spram_bank_ctrl #(
    parameter int LANES      = 1,
    parameter int BANKS      = 1,
    parameter int IDLE_STBY  = 16,
    parameter int IDLE_SLEEP = 1024,
    parameter int WAKE_CYC   = 4,
    localparam int AW = 14 + $clog2(BANKS),
    localparam int DW = 16 * LANES,
    localparam int MW = 4 * LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lp_en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    input  logic [MW-1:0]    req_mask,
    output logic             rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic [BANKS-1:0] bank_sleep
);
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CMAX = (IDLE_STBY > IDLE_SLEEP)
                        ? ((IDLE_STBY > WAKE_CYC) ? IDLE_STBY : WAKE_CYC)
                        : ((IDLE_SLEEP > WAKE_CYC) ? IDLE_SLEEP : WAKE_CYC);
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] STBY_LAST  = CW'(IDLE_STBY - 1);
    localparam logic [CW-1:0] SLEEP_LAST = CW'(IDLE_SLEEP - 1);
    localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_CYC - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4) ||
        !(BANKS == 1 || BANKS == 2 || BANKS == 4) ||
        (LANES * BANKS > 4)) begin : g_bad_geometry
        $error("spram_bank_ctrl: illegal LANES/BANKS combination");
    end
    if (IDLE_STBY < 1 || IDLE_SLEEP < 1 || WAKE_CYC < 1) begin : g_bad_timing
        $error("spram_bank_ctrl: IDLE_STBY, IDLE_SLEEP and WAKE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_SLEEP   = 2'd2,
        ST_WAKE    = 2'd3
    } bank_state_t;

    bank_state_t state_q [BANKS];
    bank_state_t state_d [BANKS];
    logic [CW-1:0] cnt_q [BANKS];
    logic [CW-1:0] cnt_d [BANKS];

    logic [BW-1:0] bank_sel;
    logic [BW-1:0] rd_bank_q, rd_bank_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          data_ok_q, data_ok_d;
    logic          accept;
    logic          rd_accept;
    logic [BANKS-1:0] bank_req;
    logic [BANKS-1:0] bank_cs;
    logic [BANKS-1:0] bank_stdby;
    logic [BANKS-1:0] bank_slp;
    logic [BANKS-1:0][DW-1:0] bank_dout;

    if (BANKS > 1) begin : g_bank_sel
        assign bank_sel = req_addr[AW-1:14];
    end else begin : g_single_bank
        assign bank_sel = '0;
    end

    // Ready follows the target bank only, so a parked bank never stalls traffic to others
    always_comb begin
        req_ready = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            bank_req[b]   = req_valid && (bank_sel == BW'(b));
            bank_stdby[b] = (state_q[b] == ST_STANDBY) || (state_q[b] == ST_SLEEP);
            bank_slp[b]   = (state_q[b] == ST_SLEEP);
            if (bank_sel == BW'(b)) begin
                req_ready = (state_q[b] == ST_ACTIVE);
            end
        end
        accept    = req_valid && req_ready;
        rd_accept = accept && !req_we;
        for (int b = 0; b < BANKS; b++) begin
            bank_cs[b] = accept && (bank_sel == BW'(b));
        end
    end

    // Per-bank power sequencer; a request to a parked bank only starts its wake-up,
    // the requester keeps holding until ready
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                ST_ACTIVE: begin
                    if (bank_cs[b] || !lp_en) begin
                        cnt_d[b] = '0;
                    end else if (cnt_q[b] == STBY_LAST) begin
                        state_d[b] = ST_STANDBY;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                ST_STANDBY: begin
                    if (bank_req[b] || !lp_en) begin
                        state_d[b] = ST_ACTIVE;
                        cnt_d[b]   = '0;
                    end else if (cnt_q[b] == SLEEP_LAST) begin
                        state_d[b] = ST_SLEEP;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                ST_SLEEP: begin
                    cnt_d[b] = '0;
                    if (bank_req[b] || !lp_en) begin
                        state_d[b] = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q[b] == WAKE_LAST) begin
                        state_d[b] = ST_ACTIVE;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                default: begin
                    state_d[b] = ST_ACTIVE;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    // Read response bookkeeping; data_ok keeps rsp_rdata at zero until the first
    // read after reset, since the macro output registers are not reset
    always_comb begin
        rsp_valid_d = rd_accept;
        rd_bank_d   = rd_accept ? bank_sel : rd_bank_q;
        data_ok_d   = data_ok_q || rd_accept;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                state_q[b] <= ST_ACTIVE;
                cnt_q[b]   <= '0;
            end
            rsp_valid_q <= 1'b0;
            rd_bank_q   <= '0;
            data_ok_q   <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            rsp_valid_q <= rsp_valid_d;
            rd_bank_q   <= rd_bank_d;
            data_ok_q   <= data_ok_d;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            sp256k_model u_ram (
                .clk      (clk),
                .ad       (req_addr[13:0]),
                .di       (req_wdata[16*l +: 16]),
                .maskwe   (req_mask[4*l +: 4]),
                .we       (req_we),
                .cs       (bank_cs[b]),
                .stdby    (bank_stdby[b]),
                .sleep    (bank_slp[b]),
                .pwroff_n (1'b1),
                .dout     (bank_dout[b][16*l +: 16])
            );
        end
    end

    // Output mux keyed by the registered bank of the last read
    always_comb begin
        rsp_rdata = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (data_ok_q && (rd_bank_q == BW'(b))) begin
                rsp_rdata = bank_dout[b];
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign bank_sleep = bank_slp;
endmodule

// File: tb/tb_spram_bank_ctrl.sv
module tb_spram_bank_ctrl;
    localparam int LANES = 2;
    localparam int BANKS = 2;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int MW    = 8;
    localparam logic [AW-1:0] BANK1 = 15'h4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          lp_en;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_mask;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [BANKS-1:0] bank_sleep;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [int];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            waited;
    int            total_wait;

    spram_bank_ctrl #(
        .LANES(LANES), .BANKS(BANKS),
        .IDLE_STBY(16), .IDLE_SLEEP(32), .WAKE_CYC(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lp_en      (lp_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bank_sleep (bank_sleep)
    );

    // Free-running clock and cycle counter used to time-stamp expected responses
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Holds one request until accepted, updates the reference model at the accept
    // and queues the expected read response; reports how many cycles ready was low
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [MW-1:0] mask,
                                 output int stall);
        logic [DW-1:0] word;
        exp_t e;
        stall = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stall++;
            if (stall > 100) begin
                checkOutput("accept_timeout", 32'(stall), 32'd0);
                req_valid = 1'b0;
                return;
            end
        end
        if (we) begin
            word = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
            for (int n = 0; n < MW; n++) begin
                if (mask[n]) word[4*n +: 4] = wdata[4*n +: 4];
            end
            ref_mem[int'(addr)] = word;
        end else begin
            e.data = ref_mem[int'(addr)];
            e.cyc  = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every response must match the oldest queued read, one cycle after its accept
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_rsp", rsp_rdata, '0);
                if (rsp_rdata === '0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 required no response");
                end
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("rsp_data", rsp_rdata, e.data);
                checkOutput("rsp_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst = 1'b1; lp_en = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0;
        idle(2);
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_bank_sleep", 32'(bank_sleep), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two banks, then read both back-to-back
        applyStimulus(1'b1, 15'h0010, 32'hDEAD_BEEF, 8'hFF, waited);
        applyStimulus(1'b1, BANK1 | 15'h0010, 32'h1234_5678, 8'hFF, waited);
        applyStimulus(1'b0, 15'h0010, '0, '0, waited);
        applyStimulus(1'b0, BANK1 | 15'h0010, '0, '0, waited);
        idle(2);
        @(negedge clk);
        checkOutput("rdata_hold", rsp_rdata, 32'h1234_5678);
        checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);

        // Masked write, then read immediately after
        applyStimulus(1'b1, 15'h0005, 32'h0000_FFFF, 8'hFF, waited);
        applyStimulus(1'b1, 15'h0005, 32'h0000_0000, 8'h05, waited);
        applyStimulus(1'b0, 15'h0005, '0, '0, waited);
        applyStimulus(1'b1, 15'h0005, 32'hAAAA_AAAA, 8'h00, waited);
        applyStimulus(1'b0, 15'h0005, '0, '0, waited);
        checkOutput("t2_model", ref_mem[5], 32'h0000_F0F0);

        // lp_en=0 keeps everything awake
        idle(60);
        @(negedge clk);
        checkOutput("lp_off_awake", 32'(bank_sleep), 32'd0);

        // Idle into sleep: 48 cycles exactly
        @(posedge clk); #1;
        lp_en = 1'b1;
        repeat (47) @(posedge clk);
        @(negedge clk);
        checkOutput("sleep_not_yet", 32'(bank_sleep), 32'd0);
        @(negedge clk);
        checkOutput("sleep_entered", 32'(bank_sleep), 32'd3);
        @(posedge clk); #1;
        applyStimulus(1'b0, 15'h0010, '0, '0, waited);
        checkOutput("wake_stall", 32'(waited), 32'd5);
        @(negedge clk);
        checkOutput("bank1_still_asleep", 32'(bank_sleep), 32'd2);
        @(posedge clk); #1;

        // Streaming reads to the awake bank
        total_wait = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 15'h0010 : 15'h0005, '0, '0, waited);
            total_wait += waited;
        end
        checkOutput("stream_no_stall", 32'(total_wait), 32'd0);
        @(negedge clk);
        checkOutput("stream_bank1_asleep", 32'(bank_sleep), 32'd2);
        @(posedge clk); #1;

        // Standby exit costs one cycle
        idle(20);
        applyStimulus(1'b0, 15'h0005, '0, '0, waited);
        checkOutput("standby_stall", 32'(waited), 32'd1);

        // Reset while bank 1 is waking with a read pending
        req_valid = 1'b1; req_we = 1'b0; req_addr = BANK1 | 15'h0010;
        @(negedge clk);
        checkOutput("sleep_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_wake_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_wake_sleep", 32'(bank_sleep), 32'd0);
        checkOutput("rst_wake_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, BANK1 | 15'h0010, '0, '0, waited);
        checkOutput("post_rst_stall", 32'(waited), 32'd0);

        // Reset on the same edge as a read accept suppresses the response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0010; rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_read_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_read_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;

        // Directed mixed sequence over a small address set with lp_en toggling
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b1, ((a % 2) ? BANK1 : 15'h0) | 15'(a + 32),
                          32'h1111_1111 * (a + 1), 8'hFF, waited);
        end
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] addr;
            addr = (($urandom_range(1) == 1) ? BANK1 : 15'h0) | 15'($urandom_range(7) + 32);
            if ($urandom_range(15) == 0) lp_en = ~lp_en;
            if (!ref_mem.exists(int'(addr))) addr = 15'd32;
            applyStimulus($urandom_range(1) == 1, addr, $urandom, 8'($urandom), waited);
            if ($urandom_range(7) == 0) idle($urandom_range(60));
        end

        idle(3);
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] timeout");
    end
endmodule
